// File: rtl/sync_read_mem_init_if.sv
// Bus bundle for sync_read_mem_init: flush/ready handshake, masked write port,
// registered read port with rvalid and per-lane parity error.
interface sync_read_mem_init_if #(
  parameter int DATA_WIDTH = 2,
  parameter int LANES      = 4,
  parameter int ADDR_WIDTH = 11
);
  logic                          flush;
  logic                          ready;
  logic                          wen;
  logic [ADDR_WIDTH-1:0]         waddr;
  logic [LANES-1:0]              cs;
  logic [LANES*DATA_WIDTH-1:0]   wdata;
  logic                          par_inj;
  logic                          ren;
  logic [ADDR_WIDTH-1:0]         raddr;
  logic [LANES*DATA_WIDTH-1:0]   rdata;
  logic                          rvalid;
  logic [LANES-1:0]              rerr;

  modport master (
    output flush, wen, waddr, cs, wdata, par_inj, ren, raddr,
    input  ready, rdata, rvalid, rerr
  );

  modport slave (
    input  flush, wen, waddr, cs, wdata, par_inj, ren, raddr,
    output ready, rdata, rvalid, rerr
  );
endinterface

// File: rtl/sync_read_mem_init.sv
// Lane-masked sync-read memory with a hardware clear sweep after reset/flush.
// Optional per-lane parity storage and checking under SYNC_READ_MEM_PARITY_EN.
module sync_read_mem_init #(
  parameter int                    DEPTH      = 2048,
  parameter int                    DATA_WIDTH = 2,
  parameter int                    LANES      = 4,
  parameter int                    ADDR_WIDTH = $clog2(DEPTH),
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0,
  parameter int                    RDW_MODE   = 0
) (
  input  logic                clk,
  input  logic                reset,
  sync_read_mem_init_if.slave bus
);
  localparam int                    DW        = LANES * DATA_WIDTH;
  localparam logic [DW-1:0]         INIT_WORD = {LANES{INIT_VALUE}};
  localparam bit                    POW2      = (DEPTH == (1 << ADDR_WIDTH));
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST      = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_READY} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DW-1:0]         rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic [LANES-1:0]      rerr_q, rerr_d;

  logic [DW-1:0]         mem_q [DEPTH];
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [LANES-1:0]      mem_wmask;
  logic [DW-1:0]         mem_wdata;
  logic [DW-1:0]         rd_word;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return POW2 || ({1'b0, a} < DEPTH_X);
  endfunction

`ifdef SYNC_READ_MEM_PARITY_EN
  logic [LANES-1:0] par_q [DEPTH];
  logic [LANES-1:0] mem_wpar;

  function automatic logic [LANES-1:0] lane_parity(input logic [DW-1:0] d);
    logic [LANES-1:0] p;
    for (int i = 0; i < LANES; i++) p[i] = ^d[i*DATA_WIDTH +: DATA_WIDTH];
    return p;
  endfunction
`else
  logic unused_par_inj;
  assign unused_par_inj = bus.par_inj;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    rerr_d    = '0;
    mem_we    = 1'b0;
    mem_waddr = cnt_q;
    mem_wmask = '0;
    mem_wdata = INIT_WORD;
    rd_word   = in_range(bus.raddr) ? mem_q[bus.raddr] : INIT_WORD;
`ifdef SYNC_READ_MEM_PARITY_EN
    mem_wpar  = lane_parity(INIT_WORD);
`endif
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_wmask = '1;
        cnt_d     = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == LAST) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      default: begin
        if (bus.flush) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end else begin
          if (bus.wen && in_range(bus.waddr)) begin
            mem_we    = 1'b1;
            mem_waddr = bus.waddr;
            mem_wmask = bus.cs;
            mem_wdata = bus.wdata;
`ifdef SYNC_READ_MEM_PARITY_EN
            mem_wpar  = lane_parity(bus.wdata) ^ {LANES{bus.par_inj}};
`endif
          end
          if (bus.ren) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
`ifdef SYNC_READ_MEM_PARITY_EN
            if (in_range(bus.raddr)) rerr_d = lane_parity(rd_word) ^ par_q[bus.raddr];
`endif
            // New-data mode forwards only the lanes actually being written.
            if (RDW_MODE == 0 && mem_we && bus.waddr == bus.raddr) begin
              for (int i = 0; i < LANES; i++) begin
                if (bus.cs[i]) begin
                  rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.wdata[i*DATA_WIDTH +: DATA_WIDTH];
                  rerr_d[i] = 1'b0;
                end
              end
            end
          end
        end
      end
    endcase
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_INIT;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_wmask[i]) begin
          mem_q[mem_waddr][i*DATA_WIDTH +: DATA_WIDTH] <= mem_wdata[i*DATA_WIDTH +: DATA_WIDTH];
`ifdef SYNC_READ_MEM_PARITY_EN
          par_q[mem_waddr][i] <= mem_wpar[i];
`endif
        end
      end
    end
  end

  assign bus.ready  = (state_q == ST_READY);
  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.rerr   = rerr_q;
endmodule
